// File: rtl/eth_tx_framer_if.sv
// 8-bit AXI-Stream bundle used for both the payload input and the wire output of eth_tx_framer.
interface eth_tx_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: preamble/SFD, header, payload, zero pad, CRC-32 FCS, inter-frame gap.
// Define ETH_TX_VLAN_EN to add the vlan_tci port and insert an 802.1Q tag after the source MAC.
module eth_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_LEN      = 12,
  parameter int unsigned MIN_PAYLOAD  = 46,
  parameter int unsigned MAX_PAYLOAD  = 1500
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic [47:0]            dst_mac,
  input  logic [47:0]            src_mac,
  input  logic [15:0]            eth_type,
`ifdef ETH_TX_VLAN_EN
  input  logic [15:0]            vlan_tci,
`endif
  eth_tx_framer_if.slave         s_axis,
  eth_tx_framer_if.master        m_axis,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt
);

`ifdef ETH_TX_VLAN_EN
  localparam int unsigned HdrLen  = 18;
  localparam int unsigned PadThrI = (MIN_PAYLOAD > 4) ? MIN_PAYLOAD - 4 : 0;
`else
  localparam int unsigned HdrLen  = 14;
  localparam int unsigned PadThrI = MIN_PAYLOAD;
`endif
  localparam int unsigned HdrBits = HdrLen * 8;
  localparam logic [15:0] PreLen  = 16'(PREAMBLE_LEN);
  localparam logic [15:0] HdrLast = 16'(HdrLen - 1);
  localparam logic [15:0] IfgLast = 16'(IFG_LEN - 1);
  localparam logic [15:0] PadThr  = 16'(PadThrI);
  localparam logic [15:0] MaxPay  = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    StIdle, StPrea, StHead, StData, StDrop, StPad, StFcs, StIfg
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          pay_q, pay_d;
  logic [HdrBits-1:0]   hdr_q, hdr_d;
  logic [HdrBits-1:0]   hdr_in;
  logic [31:0]          crc_q, crc_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic                 tuser_q, tuser_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic                 s_tready;
  logic [15:0]          pay_inc;
  logic [31:0]          fcs;

`ifdef ETH_TX_VLAN_EN
  assign hdr_in = {dst_mac, src_mac, 16'h8100, vlan_tci, eth_type};
`else
  assign hdr_in = {dst_mac, src_mac, eth_type};
`endif

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign pay_inc = pay_q + 16'd1;
  assign fcs     = ~crc_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pay_d       = pay_q;
    hdr_d       = hdr_q;
    crc_d       = crc_q;
    tdata_d     = 8'h00;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    s_tready    = 1'b0;
    case (state_q)
      StIdle: begin
        if (s_axis.tvalid) begin
          hdr_d    = hdr_in;
          crc_d    = 32'hFFFF_FFFF;
          cnt_d    = 16'd1;
          pay_d    = 16'd0;
          tdata_d  = 8'h55;
          tvalid_d = 1'b1;
          state_d  = StPrea;
        end
      end
      StPrea: begin
        tvalid_d = 1'b1;
        if (cnt_q < PreLen) begin
          tdata_d = 8'h55;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          tdata_d = 8'hD5;
          cnt_d   = 16'd0;
          state_d = StHead;
        end
      end
      StHead: begin
        tvalid_d = 1'b1;
        tdata_d  = hdr_q[HdrBits-1 -: 8];
        hdr_d    = hdr_q << 8;
        crc_d    = crc_step(crc_q, tdata_d);
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q == HdrLast) begin
          cnt_d   = 16'd0;
          state_d = StData;
        end
      end
      StData: begin
        s_tready = 1'b1;
        if (!s_axis.tvalid) begin
          // Underrun: the wire cannot stall, so the frame is abandoned.
          tuser_d   = 1'b1;
          err_cnt_d = err_cnt_q + 16'd1;
          state_d   = StDrop;
        end else if (!s_axis.tlast && pay_inc == MaxPay) begin
          tuser_d   = 1'b1;
          err_cnt_d = err_cnt_q + 16'd1;
          state_d   = StDrop;
        end else begin
          pay_d    = pay_inc;
          tvalid_d = 1'b1;
          tdata_d  = s_axis.tdata;
          crc_d    = crc_step(crc_q, s_axis.tdata);
          if (s_axis.tlast) begin
            cnt_d   = 16'd0;
            state_d = (pay_inc < PadThr) ? StPad : StFcs;
          end
        end
      end
      StDrop: begin
        s_tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          cnt_d   = 16'd0;
          state_d = StIfg;
        end
      end
      StPad: begin
        tvalid_d = 1'b1;
        tdata_d  = 8'h00;
        crc_d    = crc_step(crc_q, 8'h00);
        pay_d    = pay_inc;
        if (pay_inc >= PadThr) begin
          cnt_d   = 16'd0;
          state_d = StFcs;
        end
      end
      StFcs: begin
        tvalid_d = 1'b1;
        tdata_d  = fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q[1:0] == 2'd3) begin
          tlast_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = 16'd0;
          state_d     = StIfg;
        end
      end
      StIfg: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= IfgLast) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      pay_q       <= 16'd0;
      hdr_q       <= '0;
      crc_q       <= 32'd0;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_q       <= pay_d;
      hdr_q       <= hdr_d;
      crc_q       <= crc_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign s_axis.tready = s_tready;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule
